t_controlled_sync_counter: RTL and testbench
============================================

T_CONTROLLED_SYNC_COUNTER -- requirements
Module: t_controlled_sync_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MODULUS, default 0: count modulus; 0 means 2**WIDTH, otherwise legal range 2..2**WIDTH.
REQ-003 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous clear of count to 0.
REQ-006 load  input  1  synchronous parallel load of load_value.
REQ-007 load_value  input  WIDTH  value to load.
REQ-008 enable  input  1  count enable.
REQ-009 up_down  input  1  direction: 1 = up, 0 = down.
REQ-010 count  output  WIDTH  current count, registered.
REQ-011 terminal_count  output  1  combinational flag: count at terminal value for the current direction.
REQ-012 wrap  output  1  registered one-cycle pulse: the previous edge wrapped the count.

Function
REQ-013 Let M = MODULUS, or 2**WIDTH when MODULUS = 0; count SHALL always hold a value in 0..M-1.
REQ-014 Per-edge priority SHALL be: clear, then load, then enable-count, then hold.
REQ-015 clear=1: count SHALL become 0 next edge and wrap SHALL be 0, regardless of load or enable.
REQ-016 load=1 (clear=0): count SHALL become load_value next edge, or M-1 if load_value >= M; wrap SHALL be 0.
REQ-017 enable=1, up_down=1 (clear=0, load=0): count SHALL become count+1, or 0 when count = M-1.
REQ-018 enable=1, up_down=0 (clear=0, load=0): count SHALL become count-1, or M-1 when count = 0.
REQ-019 enable=0 (clear=0, load=0): count SHALL hold and wrap SHALL be 0.
REQ-020 Latency: every control input SHALL take effect on count exactly one rising edge after it is sampled.
REQ-021 terminal_count SHALL be 1 when (up_down=1 and count=M-1) or (up_down=0 and count=0), independent of enable; it SHALL be 0 otherwise.
REQ-022 wrap SHALL be 1 for exactly the one cycle after an edge on which enable=1, clear=0, load=0 and terminal_count=1.
REQ-023 A direction change on any cycle SHALL take effect on that edge with no dead cycle.
REQ-024 Each count bit SHALL be held in a T flip-flop whose T input is 1 exactly when that bit differs between the current and next count (synchronous design, no ripple clocking).

Reset
REQ-025 reset_n=0 SHALL force count=0 and wrap=0 immediately, without waiting for a clock edge.
REQ-026 While reset_n=0, all inputs SHALL be ignored; terminal_count SHALL reflect count=0 and the current up_down.
REQ-027 After reset_n rises, the first rising edge SHALL apply the normal rules to count=0.
REQ-028 Reset asserted mid-count or mid-load SHALL abandon the operation with no partial update.

Structure
REQ-029 Shared package ctr_pkg SHALL hold the direction constants DIR_UP=1 and DIR_DOWN=0, plus a function computing the effective modulus M from (WIDTH, MODULUS).
REQ-030 One sub-module, t_flip_flop_r, SHALL be a T flip-flop with asynchronous active-low reset to 0; it SHALL be instantiated WIDTH times through a generate loop.
REQ-031 Next-count and terminal logic SHALL be combinational in the parent; the only registers outside the flip-flops SHALL be wrap.
REQ-032 Illegal parameter values SHALL be rejected at elaboration.

Verification
REQ-033 WIDTH=4, MODULUS=0: reset, then enable=1, up for 17 edges -> count 0,1..15,0,1; terminal_count=1 at 15; wrap=1 only in the cycle showing 0.
REQ-034 WIDTH=4, MODULUS=10, down from reset -> count 0,9,8..0,9; wrap pulses after each 0->9 step.
REQ-035 WIDTH=4, MODULUS=10: load=1 with load_value=12 -> count=9; next, clear=1 with load=1 and enable=1 -> count=0, wrap=0.
REQ-036 Count up to 7, then enable=0 for 3 edges -> count holds 7; then up_down=0 with enable=1 -> 6 on the next edge.
REQ-037 At count=5, assert reset_n=0 between edges -> count=0 before the next edge; hold low across 2 edges -> count stays 0.
REQ-038 WIDTH=8, MODULUS=0, load 255, count up -> count=0 and wrap=1; then up_down=0 -> terminal_count=1 at 0.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared counter definitions: direction encoding and effective-modulus helper.
// Pure constants and functions; no logic, no latency, no backpressure.
package ctr_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // MODULUS of 0 selects the full binary range of the counter.
  function automatic longint unsigned eff_modulus(input int width, input longint unsigned modulus);
    return (modulus == 0) ? (longint'(1) << width) : modulus;
  endfunction

endpackage

// File: rtl/t_flip_flop_r.sv
// Single T flip-flop, async active-low reset to 0; toggles on a rising edge when i_t=1.
// Latency one edge; no backpressure.
module t_flip_flop_r (
  input  logic clock,
  input  logic reset_n,
  input  logic i_t,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= 1'b0;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/t_controlled_sync_counter.sv
// Modulo-M up/down counter with clear/load built from T flip-flops, plus terminal and wrap flags.
// Latency: controls act one edge after sampling; no backpressure (every edge is accepted).
module t_controlled_sync_counter
  import ctr_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             terminal_count,
  output logic             wrap
);

  localparam longint unsigned M   = eff_modulus(WIDTH, MODULUS);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(M - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("t_controlled_sync_counter: WIDTH must be in 2..32");
  end
  if (MODULUS != 0 && (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH))) begin : g_bad_modulus
    $error("t_controlled_sync_counter: MODULUS must be 0 or in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_terminal;
  logic             w_wrap_next;
  logic             r_wrap;

  always_comb begin
    w_next = w_count;
    if (clear) begin
      w_next = '0;
    end else if (load) begin
      w_next = (64'(load_value) >= M) ? MAX : load_value;
    end else if (enable) begin
      if (up_down == DIR_UP) begin
        w_next = (w_count == MAX) ? '0 : w_count + ONE;
      end else begin
        w_next = (w_count == '0) ? MAX : w_count - ONE;
      end
    end
  end

  assign w_terminal  = (up_down == DIR_UP)   ? (w_count == MAX)
                     : (up_down == DIR_DOWN) ? (w_count == '0)
                     : 1'b0;
  assign w_wrap_next = enable & ~clear & ~load & w_terminal;

  // Each bit toggles exactly when it must change to reach the next count.
  assign w_t = w_count ^ w_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_flip_flop_r u_tff (
      .clock   (clock),
      .reset_n (reset_n),
      .i_t     (w_t[i]),
      .o_q     (w_count[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_next;
    end
  end

  assign count          = w_count;
  assign terminal_count = w_terminal;
  assign wrap           = r_wrap;

endmodule

// File: tb/tb_t_controlled_sync_counter.sv
// Drives three counter configurations in lockstep (4-bit full, 4-bit mod 10, 8-bit full)
// and compares them every edge against an arithmetic modulo-M reference model.
module tb_t_controlled_sync_counter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clear, load, enable, up_down;
  logic [7:0] load_value;
  logic [3:0] cnt0, cnt1;
  logic [7:0] cnt2;
  logic [2:0] tc, wr;

  int errors = 0;
  int checks = 0;

  int m_cnt  [3];
  bit m_wrap [3];
  int m_mod  [3] = '{16, 10, 256};
  int m_bits [3] = '{4, 4, 8};

  always #5 clock = ~clock;

  t_controlled_sync_counter #(.WIDTH(4), .MODULUS(0)) u0 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value[3:0]), .enable(enable), .up_down(up_down),
    .count(cnt0), .terminal_count(tc[0]), .wrap(wr[0]));

  t_controlled_sync_counter #(.WIDTH(4), .MODULUS(10)) u1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value[3:0]), .enable(enable), .up_down(up_down),
    .count(cnt1), .terminal_count(tc[1]), .wrap(wr[1]));

  t_controlled_sync_counter #(.WIDTH(8), .MODULUS(0)) u2 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .enable(enable), .up_down(up_down),
    .count(cnt2), .terminal_count(tc[2]), .wrap(wr[2]));

  function automatic int obs_cnt(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic bit exp_tc(input int k);
    return up_down ? (m_cnt[k] == m_mod[k] - 1) : (m_cnt[k] == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k]  = 0;
      m_wrap[k] = 1'b0;
    end
  endtask

  // Reference behaviour: arithmetic modulo M, clamp on oversized loads.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int v;
      v = int'(load_value) % (1 << m_bits[k]);
      if (clear) begin
        m_cnt[k] = 0; m_wrap[k] = 1'b0;
      end else if (load) begin
        m_cnt[k] = (v >= m_mod[k]) ? m_mod[k] - 1 : v; m_wrap[k] = 1'b0;
      end else if (enable) begin
        if (up_down) begin
          m_wrap[k] = (m_cnt[k] == m_mod[k] - 1);
          m_cnt[k]  = (m_cnt[k] + 1) % m_mod[k];
        end else begin
          m_wrap[k] = (m_cnt[k] == 0);
          m_cnt[k]  = (m_cnt[k] + m_mod[k] - 1) % m_mod[k];
        end
      end else begin
        m_wrap[k] = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic [7:0] lv, input logic e, input logic u);
    clear = c; load = l; load_value = lv; enable = e; up_down = u;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; load = 1'b1; load_value = 8'hA5; enable = 1'b1; up_down = 1'b0;
    model_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (obs_cnt(k) !== m_cnt[k]) begin errors++; $display("FAIL reset u%0d count: got %0d expected %0d", k, obs_cnt(k), m_cnt[k]); end
      if (wr[k] !== m_wrap[k]) begin errors++; $display("FAIL reset u%0d wrap: got %b expected %b", k, wr[k], m_wrap[k]); end
      if (tc[k] !== exp_tc(k)) begin errors++; $display("FAIL reset u%0d terminal: got %b expected %b", k, tc[k], exp_tc(k)); end
    end
    up_down = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (obs_cnt(k) !== m_cnt[k]) begin errors++; $display("FAIL reset_hold u%0d count: got %0d expected %0d", k, obs_cnt(k), m_cnt[k]); end
      if (wr[k] !== m_wrap[k]) begin errors++; $display("FAIL reset_hold u%0d wrap: got %b expected %b", k, wr[k], m_wrap[k]); end
      if (tc[k] !== exp_tc(k)) begin errors++; $display("FAIL reset_hold u%0d terminal: got %b expected %b", k, tc[k], exp_tc(k)); end
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checks += 2;
      if (cnt0 !== 4'(i % 16)) begin errors++; $display("FAIL up_seq edge %0d count: got %0d expected %0d", i, cnt0, i % 16); end
      if (wr[0] !== (i == 16)) begin errors++; $display("FAIL up_seq edge %0d wrap: got %b expected %b", i, wr[0], (i == 16)); end
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (obs_cnt(k) !== m_cnt[k]) begin errors++; $display("FAIL up_wrap u%0d count: got %0d expected %0d", k, obs_cnt(k), m_cnt[k]); end
        if (wr[k] !== m_wrap[k]) begin errors++; $display("FAIL up_wrap u%0d wrap: got %b expected %b", k, wr[k], m_wrap[k]); end
        if (tc[k] !== exp_tc(k)) begin errors++; $display("FAIL up_wrap u%0d terminal: got %b expected %b", k, tc[k], exp_tc(k)); end
      end
    end
  endtask

  task automatic test_down_modulus();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checks += 2;
      if (cnt1 !== 4'((10 - i % 10) % 10)) begin errors++; $display("FAIL down_mod10 edge %0d count: got %0d expected %0d", i, cnt1, (10 - i % 10) % 10); end
      if (wr[1] !== (i == 1 || i == 11)) begin errors++; $display("FAIL down_mod10 edge %0d wrap: got %b expected %b", i, wr[1], (i == 1 || i == 11)); end
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (obs_cnt(k) !== m_cnt[k]) begin errors++; $display("FAIL down u%0d count: got %0d expected %0d", k, obs_cnt(k), m_cnt[k]); end
        if (wr[k] !== m_wrap[k]) begin errors++; $display("FAIL down u%0d wrap: got %b expected %b", k, wr[k], m_wrap[k]); end
        if (tc[k] !== exp_tc(k)) begin errors++; $display("FAIL down u%0d terminal: got %b expected %b", k, tc[k], exp_tc(k)); end
      end
    end
  endtask

  task automatic test_load_clamp();
    for (int s = 0; s < 2; s++) begin
      if (s == 0) drive(1'b0, 1'b1, 8'd12, 1'b0, 1'b1);
      else        drive(1'b1, 1'b1, 8'd12, 1'b1, 1'b1);
      checks += 2;
      if (cnt1 !== ((s == 0) ? 4'd9 : 4'd0)) begin errors++; $display("FAIL load_clamp step %0d count: got %0d expected %0d", s, cnt1, (s == 0) ? 9 : 0); end
      if (wr[1] !== 1'b0) begin errors++; $display("FAIL load_clamp step %0d wrap: got %b expected 0", s, wr[1]); end
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (obs_cnt(k) !== m_cnt[k]) begin errors++; $display("FAIL load u%0d count: got %0d expected %0d", k, obs_cnt(k), m_cnt[k]); end
        if (wr[k] !== m_wrap[k]) begin errors++; $display("FAIL load u%0d wrap: got %b expected %b", k, wr[k], m_wrap[k]); end
        if (tc[k] !== exp_tc(k)) begin errors++; $display("FAIL load u%0d terminal: got %b expected %b", k, tc[k], exp_tc(k)); end
      end
    end
  endtask

  task automatic test_hold_and_reverse();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int s = 1; s <= 11; s++) begin
      drive(1'b0, 1'b0, 8'h00, (s <= 7 || s == 11), (s != 11));
      checks++;
      if (cnt0 !== ((s <= 7) ? 4'(s) : (s <= 10) ? 4'd7 : 4'd6)) begin
        errors++; $display("FAIL hold_reverse step %0d count: got %0d", s, cnt0);
      end
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (obs_cnt(k) !== m_cnt[k]) begin errors++; $display("FAIL hold u%0d count: got %0d expected %0d", k, obs_cnt(k), m_cnt[k]); end
        if (wr[k] !== m_wrap[k]) begin errors++; $display("FAIL hold u%0d wrap: got %b expected %b", k, wr[k], m_wrap[k]); end
        if (tc[k] !== exp_tc(k)) begin errors++; $display("FAIL hold u%0d terminal: got %b expected %b", k, tc[k], exp_tc(k)); end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int s = 0; s < 5; s++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (cnt0 !== 4'd0) begin errors++; $display("FAIL async_reset immediate count: got %0d expected 0", cnt0); end
    for (int s = 0; s < 3; s++) begin
      if (s == 1) begin
        load = 1'b1; load_value = 8'd3;
        @(posedge clock);
        @(posedge clock);
        #1;
      end
      if (s == 2) begin
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      end
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (obs_cnt(k) !== m_cnt[k]) begin errors++; $display("FAIL async_reset s%0d u%0d count: got %0d expected %0d", s, k, obs_cnt(k), m_cnt[k]); end
        if (wr[k] !== m_wrap[k]) begin errors++; $display("FAIL async_reset s%0d u%0d wrap: got %b expected %b", s, k, wr[k], m_wrap[k]); end
        if (tc[k] !== exp_tc(k)) begin errors++; $display("FAIL async_reset s%0d u%0d terminal: got %b expected %b", s, k, tc[k], exp_tc(k)); end
      end
    end
  endtask

  task automatic test_load_max();
    drive(1'b0, 1'b1, 8'd255, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checks += 2;
    if (cnt2 !== 8'd0) begin errors++; $display("FAIL load_max count: got %0d expected 0", cnt2); end
    if (wr[2] !== 1'b1) begin errors++; $display("FAIL load_max wrap: got %b expected 1", wr[2]); end
    enable = 1'b0; up_down = 1'b0;
    #1;
    checks++;
    if (tc !== 3'b111) begin errors++; $display("FAIL load_max terminal_down: got %b expected 111", tc); end
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (obs_cnt(k) !== m_cnt[k]) begin errors++; $display("FAIL load_max u%0d count: got %0d expected %0d", k, obs_cnt(k), m_cnt[k]); end
      if (wr[k] !== m_wrap[k]) begin errors++; $display("FAIL load_max u%0d wrap: got %b expected %b", k, wr[k], m_wrap[k]); end
      if (tc[k] !== exp_tc(k)) begin errors++; $display("FAIL load_max u%0d terminal: got %b expected %b", k, tc[k], exp_tc(k)); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0), 8'($urandom),
            ($urandom_range(0, 3) != 0), 1'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
      end
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (obs_cnt(k) !== m_cnt[k]) begin errors++; $display("FAIL random n%0d u%0d count: got %0d expected %0d", n, k, obs_cnt(k), m_cnt[k]); end
        if (wr[k] !== m_wrap[k]) begin errors++; $display("FAIL random n%0d u%0d wrap: got %b expected %b", n, k, wr[k], m_wrap[k]); end
        if (tc[k] !== exp_tc(k)) begin errors++; $display("FAIL random n%0d u%0d terminal: got %b expected %b", n, k, tc[k], exp_tc(k)); end
      end
      if (!reset_n) begin
        @(negedge clock);
        reset_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_modulus();
    test_load_clamp();
    test_hold_and_reverse();
    test_async_reset();
    test_load_max();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
